// File: rtl/bongo_pkg.sv
// Shared types and helpers for the bongo move scheduler.
//   move_t     : 2-bit move code (NONE/RIGHT/LEFT/BOTH)
//   LED_W      : LED ring width
//   LED_INIT   : LED ring value after reset
//   classify() : maps the 4-bit bongo pad vector to a move class
package bongo_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    BOTH  = 2'b11
  } move_t;

  localparam int unsigned LED_W = 10;
  localparam logic [LED_W-1:0] LED_INIT = 10'b0000100000;

  // Pads 3 and 1 are the left drum, pads 2 and 0 the right drum.
  function automatic move_t classify(input logic [3:0] buttons);
    logic left;
    logic right;
    left  = buttons[3] | buttons[1];
    right = buttons[2] | buttons[0];
    if (left && right) return BOTH;
    if (left)          return LEFT;
    if (right)         return RIGHT;
    return NONE;
  endfunction

endpackage

// File: rtl/bongo_move_scheduler_if.sv
// Bus between the bongo decoder/LED board and the move scheduler.
//   buttons    : decoded bongo pads (into the scheduler)
//   leds       : LED ring
//   move_valid : one-cycle pulse per applied move
//   move_code  : applied move code, valid with move_valid
//   fifo_full  : move queue full
//   drop_count : saturating count of dropped moves
// Modports: slave = scheduler side, master = driver/observer side.
interface bongo_move_scheduler_if;
  import bongo_pkg::*;

  logic [3:0]       buttons;
  logic [LED_W-1:0] leds;
  logic             move_valid;
  logic [1:0]       move_code;
  logic             fifo_full;
  logic [7:0]       drop_count;

  modport slave (
    input  buttons,
    output leds, move_valid, move_code, fifo_full, drop_count
  );

  modport master (
    output buttons,
    input  leds, move_valid, move_code, fifo_full, drop_count
  );

endinterface

// File: rtl/move_fifo.sv
// Synchronous FIFO for queued moves.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the queue)
//   push, din   : write request and data
//   pop, dout   : read request and head-of-queue data
//   empty, full : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module move_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bongo_move_scheduler.sv
// Bongo move scheduler: samples the pad vector on a divided tick, debounces the
// move class, queues class changes as moves and applies them to the LED ring at
// a rate-limited step interval.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bongo_move_scheduler_if (buttons in; leds,
//                move_valid, move_code, fifo_full, drop_count out)
module bongo_move_scheduler
  import bongo_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  bongo_move_scheduler_if.slave bus
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned StepW = $clog2(STEP_CYCLES + 1);

  logic [DivW-1:0]  div_q;
  logic             tick;
  move_t            cand_q, cand_d, stable_q, stable_d, sample;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop, drop;
  logic [StepW-1:0] step_q;
  logic [1:0]       fifo_dout;
  logic             fifo_empty, fifo_full;
  logic [LED_W-1:0] leds_q;
  logic             move_valid_q;
  logic [1:0]       move_code_q;
  logic [7:0]       drop_q;

  function automatic logic [LED_W-1:0] apply_move(input logic [LED_W-1:0] l, input move_t m);
    case (m)
      LEFT:    return {l[LED_W-2:0], l[LED_W-1]};
      RIGHT:   return {l[0], l[LED_W-1:1]};
      BOTH:    return (l << 1) | (l >> 1);
      default: return l;
    endcase
  endfunction

  assign tick = (div_q == DivW'(CLK_DIV - 1));

  // Debounce: stable follows cand once DEBOUNCE consecutive ticks agree; every
  // stable change to a non-NONE class becomes one queued move.
  always_comb begin
    sample   = classify(bus.buttons);
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    push     = 1'b0;
    if (tick) begin
      if (sample != cand_q) begin
        cand_d = sample;
        cnt_d  = CntW'(1);
      end else if (cnt_q != CntW'(DEBOUNCE)) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_d == CntW'(DEBOUNCE) && cand_d != stable_q) begin
        stable_d = cand_d;
        push     = (cand_d != NONE);
      end
    end
  end

  // Pop uses the registered empty flag, so a fresh push waits at least a clock.
  assign pop  = !fifo_empty && (step_q == '0);
  assign drop = push && fifo_full && !pop;

  move_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (stable_d),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      cand_q       <= NONE;
      cnt_q        <= '0;
      stable_q     <= NONE;
      step_q       <= '0;
      leds_q       <= LED_INIT;
      move_valid_q <= 1'b0;
      move_code_q  <= 2'b00;
      drop_q       <= '0;
    end else begin
      div_q    <= tick ? '0 : div_q + DivW'(1);
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      move_valid_q <= pop;
      if (pop) begin
        step_q      <= StepW'(STEP_CYCLES - 1);
        leds_q      <= apply_move(leds_q, move_t'(fifo_dout));
        move_code_q <= fifo_dout;
      end else if (step_q != '0) begin
        step_q <= step_q - StepW'(1);
      end
    end
  end

  assign bus.leds       = leds_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_code  = move_code_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.drop_count = drop_q;

endmodule

// File: doc/bongo_move_scheduler.md
# bongo_move_scheduler

Turns the DK-bongo button vector decoded by the bongo controller into discrete LEFT / RIGHT / BOTH move events and applies them to the 10-LED ring. Sits between the bongo decoder (4-bit `buttons`) and the board LEDs. Samples buttons on a divided tick, debounces them and detects gesture changes. Moves are queued in a small FIFO and drained at a rate-limited step interval, so rapid drumming is buffered, not lost. Excess moves are dropped and counted.

## Interface
- `CLK_DIV`, 100000: clocks per sample tick (≥2).
- `DEBOUNCE`, 3: consecutive agreeing ticks needed to accept a new class (≥1).
- `STEP_CYCLES`, 2500000: minimum clocks between applied moves (≥1).
- `FIFO_DEPTH`, 4: move queue depth (power of 2).
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `buttons` input 4: bongo pads, same clock domain, no synchronizer. Bits 3,1 = left; bits 2,0 = right.
- `leds` output 10: LED ring.
- `move_valid` output 1: one-cycle pulse when a move is applied.
- `move_code` output 2: code of the applied move; valid with `move_valid`.
- `fifo_full` output 1: queue full.
- `drop_count` output 8: dropped events, saturates at 255.

## Operation
- Move codes: NONE=00, RIGHT=01, LEFT=10, BOTH=11.
- Class of `buttons`:
  - left = b3|b1; right = b2|b0.
  - BOTH if left&right, else LEFT, else RIGHT, else NONE.
- Tick generator:
  - Counter runs 0..CLK_DIV-1.
  - `tick` is asserted on the clock where count = CLK_DIV-1, then the counter wraps.
- Debounce, evaluated on tick only:
  - `cand` holds the candidate class; `cnt` counts agreeing ticks.
  - Sampled class ≠ cand: cand ← sample, cnt ← 1.
  - Otherwise cnt increments, saturating at DEBOUNCE.
  - When cnt reaches DEBOUNCE and cand ≠ `stable`: stable ← cand.
- Event: a stable update to a value ≠ NONE pushes that value into the FIFO on the same edge.
  - Holding a class generates nothing further.
  - Returning to NONE re-arms the class.
  - LEFT→BOTH→LEFT without release gives three events.
- FIFO push:
  - Push while full with no pop in that cycle: event dropped, drop_count += 1 (saturating).
  - Push and pop in the same cycle while full: push accepted, no drop.
- Drain:
  - `step_timer` counts down to 0 by 1 per clock.
  - If the FIFO is non-empty at the start of a cycle and step_timer = 0: pop, apply, step_timer ← STEP_CYCLES-1.
  - An entry pushed into an empty FIFO pops no earlier than the next clock.
- Apply:
  - LEFT: leds ← {leds[8:0], leds[9]}.
  - RIGHT: leds ← {leds[0], leds[9:1]}.
  - BOTH: leds ← (leds<<1)|(leds>>1), truncated to 10 bits; end bits fall off.
  - move_valid = 1 and move_code = code on that same cycle.
- Reset, asynchronous, all at once:
  - leds = 10'b0000100000 (0x020).
  - FIFO empty; fifo_full = 0.
  - stable = cand = NONE; cnt = 0; tick counter = 0; step_timer = 0.
  - move_valid = 0; move_code = 00; drop_count = 0.
  - Reset mid-operation discards all queued moves.

## Timing
- Button change to stable update:
  - Ticks that sample the new class are t0..t0+DEBOUNCE-1.
  - Stable updates, and the event is pushed, on tick t0+DEBOUNCE-1.
- Push to leds update: 1 clock when the FIFO was empty and step_timer = 0.
- Spacing between successive applied moves: exactly STEP_CYCLES clocks when the queue is backlogged.
- All outputs are registered. move_valid is never high on two consecutive clocks unless STEP_CYCLES = 1.

## Structure
- Package `bongo_pkg`:
  - `move_t` enum (NONE/RIGHT/LEFT/BOTH).
  - `LED_W` = 10.
  - `LED_INIT` = 10'b0000100000.
  - `classify()` function.
- Sub-module `move_fifo`:
  - Synchronous FIFO with parameterized width/depth.
  - push, pop, dout, empty, full.
  - Same-cycle push/pop when full is legal.
- Top level contains the tick counter, debounce, event detection, step timer and LED register.

## Test plan
Use CLK_DIV=4, DEBOUNCE=3, STEP_CYCLES=8 unless noted.
1. Reset, then idle 200 clocks -> leds=0x020, move_valid never 1, drop_count=0, fifo_full=0.
2. buttons=4'b1000 held 100 clocks -> exactly one move_valid with code 10; leds 0x020→0x040.
3. buttons=4'b0100 for 2 ticks, then 0 -> no event, leds unchanged. buttons=4'b0001 for 3 ticks -> RIGHT; leds 0x020→0x010.
4. 4'b1000 held, then 4'b1100 held, with no release -> LEFT then BOTH; leds 0x020→0x040→0x0A0.
5. STEP_CYCLES=1000; six press/release LEFT gestures within 200 clocks:
   - first move applied immediately; four queued; fifo_full=1; drop_count=1.
   - four further moves at 1000-clock spacing; final leds=0x001 (wrapped).
6. From leds=0x001 apply RIGHT -> 0x200. With two moves queued, pulse rst_n low for 1 clock -> leds=0x020, FIFO empty, no move_valid afterwards.
